// File: rtl/ma_pkg.sv
// Shared types for the dictionary command sequencer and the dictionary itself.
// Command codes double as dictionary response codes.
package ma_pkg;

  localparam int MA_DATA_W = 80;
  localparam int MA_IDX_W  = 8;
  localparam int MA_DEPTH  = 256;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_COMP   = 2'd1,
    CMD_DECOMP = 2'd2,
    CMD_ERR    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_OK_COMP   = 2'd0,
    ST_OK_DECOMP = 2'd1,
    ST_ERR       = 2'd2,
    ST_TIMEOUT   = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_ISSUE = 2'd1,
    SQ_WAIT  = 2'd2,
    SQ_HOLD  = 2'd3
  } state_e;

  // Non-zero response codes only; a code that does not match the op is an error.
  function automatic status_e classify_rsp(input logic op, input logic [1:0] resp);
    if (!op && resp == CMD_COMP) return ST_OK_COMP;
    if (op && resp == CMD_DECOMP) return ST_OK_DECOMP;
    return ST_ERR;
  endfunction

endpackage

// File: rtl/ma_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module ma_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ma_cmd_sequencer.sv
// Sequences compress/decompress requests onto the dictionary command port,
// classifies the reply and returns it over a valid/ready result stream.
module ma_cmd_sequencer
  import ma_pkg::*;
#(
  parameter int DATA_W  = MA_DATA_W,
  parameter int IDX_W   = MA_IDX_W,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [IDX_W-1:0]  req_index,
  output logic [1:0]        dict_command,
  output logic [DATA_W-1:0] dict_data_in,
  output logic [IDX_W-1:0]  dict_compressed_in,
  input  logic [IDX_W-1:0]  dict_compressed_out,
  input  logic [DATA_W-1:0] dict_decompressed_out,
  input  logic [1:0]        dict_response,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [IDX_W-1:0]  rsp_index,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_comp,
  output logic [CNT_W-1:0]  cnt_decomp,
  output logic [CNT_W-1:0]  cnt_err,
  output logic [1:0]        dbg_state
);

  // Both streams are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the source holds its payload stable until that edge.

  localparam logic [1:0] S_IDLE  = SQ_IDLE;
  localparam logic [1:0] S_ISSUE = SQ_ISSUE;
  localparam logic [1:0] S_WAIT  = SQ_WAIT;
  localparam logic [1:0] S_HOLD  = SQ_HOLD;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              en_q;
  logic              op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        status_q, status_d;
  logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              capture;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    status_d   = status_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_data_d = rsp_data_q;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && req_valid) begin
          op_d    = req_op;
          data_d  = req_data;
          idx_d   = req_index;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dict_response != CMD_NOP) begin
          capture    = 1'b1;
          status_d   = classify_rsp(op_q, dict_response);
          rsp_idx_d  = (status_d == ST_OK_COMP) ? dict_compressed_out : '0;
          rsp_data_d = (status_d == ST_OK_DECOMP) ? dict_decompressed_out : '0;
        end else if (timer_q == TMR_LAST) begin
          capture    = 1'b1;
          status_d   = ST_TIMEOUT;
          rsp_idx_d  = '0;
          rsp_data_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (capture) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      op_q       <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      status_q   <= '0;
      rsp_idx_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= 1'b1;
      op_q       <= op_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      status_q   <= status_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // en_q keeps req_ready low while reset is held, without a reset-to-output path.
  assign req_ready          = en_q && (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign rsp_valid          = (state_q == S_HOLD);
  assign dict_command       = (state_q == S_ISSUE) ? (op_q ? CMD_DECOMP : CMD_COMP) : CMD_NOP;
  assign dict_data_in       = data_q;
  assign dict_compressed_in = idx_q;
  assign rsp_status         = status_q;
  assign rsp_index          = rsp_idx_q;
  assign rsp_data           = rsp_data_q;
  assign dbg_state          = state_q;

  ma_sat_counter #(.W(CNT_W)) u_cnt_comp (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (capture && (status_d == ST_OK_COMP)),
    .count_o (cnt_comp)
  );

  ma_sat_counter #(.W(CNT_W)) u_cnt_decomp (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (capture && (status_d == ST_OK_DECOMP)),
    .count_o (cnt_decomp)
  );

  ma_sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (capture && ((status_d == ST_ERR) || (status_d == ST_TIMEOUT))),
    .count_o (cnt_err)
  );

endmodule

// File: tb/tb_ma_cmd_sequencer.sv
// Bench for ma_cmd_sequencer: directed table, hand-written corner sequences,
// then randomized transactions against a transaction-level reference model.
module tb_ma_cmd_sequencer;

  localparam int DW = 80;
  localparam int IW = 8;
  localparam int TO = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_op;
  logic [DW-1:0] req_data;
  logic [IW-1:0] req_index;
  logic [1:0]    dict_command;
  logic [DW-1:0] dict_data_in;
  logic [IW-1:0] dict_compressed_in;
  logic [IW-1:0] dict_compressed_out;
  logic [DW-1:0] dict_decompressed_out;
  logic [1:0]    dict_response;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic [IW-1:0] rsp_index;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [CW-1:0] cnt_comp, cnt_decomp, cnt_err;
  logic [1:0]    dbg_state;

  ma_cmd_sequencer #(.DATA_W(DW), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_index(req_index),
    .dict_command(dict_command), .dict_data_in(dict_data_in),
    .dict_compressed_in(dict_compressed_in),
    .dict_compressed_out(dict_compressed_out),
    .dict_decompressed_out(dict_decompressed_out),
    .dict_response(dict_response),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_index(rsp_index), .rsp_data(rsp_data), .busy(busy),
    .cnt_comp(cnt_comp), .cnt_decomp(cnt_decomp), .cnt_err(cnt_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- dictionary model ----------------
  // Sees a command mid-cycle and answers m_delay cycles after the cycle that
  // follows it, for exactly one cycle.
  logic [1:0]    m_resp;
  int            m_delay;
  logic [IW-1:0] m_cout;
  logic [DW-1:0] m_dout;
  int            cd = 0;
  int            cmd_cycles = 0;

  always @(negedge clk) begin
    dict_response         = 2'd0;
    dict_compressed_out   = '0;
    dict_decompressed_out = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        dict_response         = m_resp;
        dict_compressed_out   = m_cout;
        dict_decompressed_out = m_dout;
      end
    end
    if (dict_command != 2'd0) begin
      cmd_cycles++;
      cd = m_delay + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          op;
    logic [DW-1:0] data;
    logic [IW-1:0] index;
    logic [1:0]    resp;
    int            delay;
    logic [IW-1:0] cout;
    logic [DW-1:0] dout;
    int            hold;
    logic          stall;
    logic [1:0]    est;
    logic [IW-1:0] eidx;
    logic [DW-1:0] edata;
    int            elat;
  } vec_t;

  logic [2+IW+DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int m_cc = 0, m_cd = 0, m_ce = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Transaction-level reference: what the result and its latency should be.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r = v;
    if (v.resp == 2'd0 || v.delay >= TO) begin
      r.est = 2'd3;
      r.elat = TO + 1;
    end else begin
      r.elat = 2 + v.delay;
      if (!v.op && v.resp == 2'd1) r.est = 2'd0;
      else if (v.op && v.resp == 2'd2) r.est = 2'd1;
      else r.est = 2'd2;
    end
    r.eidx  = (r.est == 2'd0) ? v.cout : '0;
    r.edata = (r.est == 2'd1) ? v.dout : '0;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input vec_t v);
    int n;
    int lat;
    logic [2+IW+DW-1:0] e;
    m_resp = v.resp; m_delay = v.delay; m_cout = v.cout; m_dout = v.dout;
    exp_q.push_back({v.est, v.eidx, v.edata});
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_idle", req_ready, 1'b1);
    req_op = v.op; req_data = v.data; req_index = v.index; req_valid = 1'b1;
    cmd_cycles = 0;
    @(posedge clk); #1;
    req_valid = v.stall;
    check("dict_command_issue", dict_command, v.op ? 2'd2 : 2'd1);
    check("dict_data_in", dict_data_in, v.data);
    check("dict_compressed_in", dict_compressed_in, v.index);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("rsp_latency", lat, v.elat);
    e = exp_q.pop_front();
    if (e[2+IW+DW-1 -: 2] == 2'd0) m_cc = sat_inc(m_cc);
    else if (e[2+IW+DW-1 -: 2] == 2'd1) m_cd = sat_inc(m_cd);
    else m_ce = sat_inc(m_ce);
    check("rsp_status", rsp_status, e[2+IW+DW-1 -: 2]);
    check("rsp_index", rsp_index, e[IW+DW-1 -: IW]);
    check("rsp_data", rsp_data, e[DW-1:0]);
    check("cnt_comp", cnt_comp, m_cc);
    check("cnt_decomp", cnt_decomp, m_cd);
    check("cnt_err", cnt_err, m_ce);
    check("cmd_one_cycle", cmd_cycles, 1);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_status", rsp_status, e[2+IW+DW-1 -: 2]);
      check("hold_index", rsp_index, e[IW+DW-1 -: IW]);
      check("hold_data", rsp_data, e[DW-1:0]);
      check("hold_req_ready", req_ready, 1'b0);
      check("hold_dict_cmd", dict_command, 2'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("after_hs_valid", rsp_valid, 1'b0);
    check("after_hs_busy", busy, 1'b0);
    check("after_hs_dict_cmd", dict_command, 2'd0);
    check("after_hs_cnt_err", cnt_err, m_ce);
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];
  vec_t rv;
  logic [95:0] rnd;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = '0; req_index = '0;
    rsp_ready = 1'b0; m_resp = 2'd0; m_delay = 0; m_cout = '0; m_dout = '0;

    //                op  data                   idx    rsp  dly cout   dout          hold stl  est   eidx   edata        elat
    tbl[0] = '{1'b0, 80'h1234,  8'h00, 2'd1, 0, 8'h05, 80'h0,      0, 1'b0, 2'd0, 8'h05, 80'h0,      2};
    tbl[1] = '{1'b1, 80'h0,     8'h03, 2'd2, 0, 8'h11, 80'hABCD,   1, 1'b0, 2'd1, 8'h00, 80'hABCD,   2};
    tbl[2] = '{1'b1, 80'h0,     8'h09, 2'd3, 0, 8'h22, 80'h77,     0, 1'b0, 2'd2, 8'h00, 80'h0,      2};
    tbl[3] = '{1'b0, 80'h55,    8'h00, 2'd2, 0, 8'h33, 80'h99,     0, 1'b0, 2'd2, 8'h00, 80'h0,      2};
    tbl[4] = '{1'b0, 80'h66,    8'h01, 2'd0, 0, 8'h44, 80'h0,      0, 1'b0, 2'd3, 8'h00, 80'h0,      5};
    tbl[5] = '{1'b0, 80'h67,    8'h02, 2'd1, 4, 8'h07, 80'h0,      2, 1'b0, 2'd3, 8'h00, 80'h0,      5};
    tbl[6] = '{1'b1, 80'h0,     8'hFE, 2'd2, 3, 8'h00, 80'hBEEF,   0, 1'b0, 2'd1, 8'h00, 80'hBEEF,   5};
    tbl[7] = '{1'b0, 80'hF00D,  8'h00, 2'd1, 0, 8'hA5, 80'h0,      5, 1'b1, 2'd0, 8'hA5, 80'h0,      2};

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_dict_cmd", dict_command, 2'd0);
    check("rst_dict_data", dict_data_in, 80'h0);
    check("rst_cnt", {cnt_comp, cnt_decomp, cnt_err}, 0);
    check("rst_dbg_state", dbg_state, 2'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", req_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // rsp_ready held high while idle has no effect
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_rsp_ready_valid", rsp_valid, 1'b0);
      check("idle_rsp_ready_busy", busy, 1'b0);
      check("idle_rsp_ready_cnt", cnt_comp, m_cc);
    end
    rsp_ready = 1'b0;

    // reset mid-WAIT: everything clears immediately, the pending reply is dropped
    m_resp = 2'd1; m_delay = 1; m_cout = 8'h3C; m_dout = '0;
    req_op = 1'b0; req_data = 80'hDEAD; req_index = 8'h00; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_cmd", dict_command, 2'd0);
    check("async_rst_data", dict_data_in, 80'h0);
    check("async_rst_valid", rsp_valid, 1'b0);
    check("async_rst_ready", req_ready, 1'b0);
    check("async_rst_cnt", {cnt_comp, cnt_decomp, cnt_err}, 0);
    m_cc = 0; m_cd = 0; m_ce = 0;
    @(negedge clk); reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid", rsp_valid, 1'b0);
      check("post_rst_cnt_comp", cnt_comp, 0);
    end

    // randomized transactions; CW=3 makes the counters saturate
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      rv.op = 1'($urandom_range(0, 1));
      rv.data = rnd[79:0];
      rv.index = 8'($urandom_range(0, 255));
      rv.resp = 2'($urandom_range(0, 3));
      rv.delay = $urandom_range(0, 5);
      rv.cout = 8'($urandom_range(0, 255));
      rnd = {$urandom, $urandom, $urandom};
      rv.dout = rnd[95:16];
      rv.hold = $urandom_range(0, 2);
      rv.stall = 1'b0;
      rv = ref_model(rv);
      run_txn(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
